// File: rtl/rgb_pkg.sv
// rgb_pkg: shared definitions for the RGB colour fader.
//   state_t      - fader FSM states (IDLE, FADE, HOLD)
//   COLOR_W      - width of one colour channel duty value
//   PAL_IDX_W    - width of the palette index
//   PALETTE      - auto-cycle colour sequence, 24-bit {r,g,b}, index 0 first
package rgb_pkg;

    localparam int unsigned COLOR_W   = 8;
    localparam int unsigned PAL_IDX_W = 3;
    localparam int unsigned PAL_SIZE  = 2 ** PAL_IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FADE,
        ST_HOLD
    } state_t;

    localparam logic [0:PAL_SIZE-1][3*COLOR_W-1:0] PALETTE = {
        24'hFF0000,
        24'hFFFF00,
        24'h00FF00,
        24'h00FFFF,
        24'h0000FF,
        24'hFF00FF,
        24'hFFFFFF,
        24'h000000
    };

endpackage

// File: rtl/rgb_step_channel.sv
// rgb_step_channel: one colour channel of the fader. Holds the current duty
// value and moves it by exactly one count toward the target on each step.
//   clk_in    - system clock
//   rst_in    - asynchronous active-low reset (value -> 0)
//   load_val  - value to preset the channel to
//   load      - preset strobe (has priority over step)
//   step      - advance one count toward target
//   target    - colour value being faded to
//   value     - current registered duty value
//   at_target - value equals target
module rgb_step_channel
    import rgb_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [COLOR_W-1:0] load_val,
    input  logic               load,
    input  logic               step,
    input  logic [COLOR_W-1:0] target,
    output logic [COLOR_W-1:0] value,
    output logic               at_target
);

    always_comb begin
        at_target = (value == target);
    end

    // Moving only while value != target means the +1/-1 can never wrap.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (step && !at_target) begin
            if (value < target) begin
                value <= value + 1'b1;
            end else begin
                value <= value - 1'b1;
            end
        end
    end

endmodule

// File: rtl/rgb_color_fader.sv
// rgb_color_fader: generates the three duty values for the PWM colour
// controller. A load request fades from the current colour to the switch
// colour, one count per prescaler tick; with auto-cycle enabled the block
// walks an internal 8-colour palette, holding between colours.
//   clk_in       - system clock
//   rst_in       - asynchronous active-low reset
//   load_in      - asynchronous load button (synchronised, rising edge used)
//   cycle_en_in  - auto-cycle enable
//   r/g/b_tgt_in - switch target colour, sampled on load accept
//   r/g/b_out    - current duty values (registered)
//   busy_out     - high while fading
//   done_out     - one-cycle pulse when a fade completes
module rgb_color_fader
    import rgb_pkg::*;
#(
    parameter int unsigned STEP_DIV   = 50000,
    parameter int unsigned HOLD_TICKS = 500
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               load_in,
    input  logic               cycle_en_in,
    input  logic [COLOR_W-1:0] r_tgt_in,
    input  logic [COLOR_W-1:0] g_tgt_in,
    input  logic [COLOR_W-1:0] b_tgt_in,
    output logic [COLOR_W-1:0] r_out,
    output logic [COLOR_W-1:0] g_out,
    output logic [COLOR_W-1:0] b_out,
    output logic               busy_out,
    output logic               done_out
);

    localparam int unsigned PS_W = $clog2(STEP_DIV);
    localparam int unsigned HC_W = $clog2(HOLD_TICKS + 1);
    localparam logic [PS_W-1:0] PS_LAST   = PS_W'(STEP_DIV - 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_TICKS - 1);

    logic                 sync1, sync2, sync3;
    logic                 load_acc;
    logic [PS_W-1:0]      ps_cnt;
    logic                 tick;
    logic                 ps_clr;
    logic                 step;
    logic [HC_W-1:0]      hold_cnt;
    state_t               state;
    logic [PAL_IDX_W-1:0] idx;
    logic [COLOR_W-1:0]   tgt_r, tgt_g, tgt_b;
    logic                 r_at, g_at, b_at;
    logic                 all_at;
    logic [3*COLOR_W-1:0] pal_color;

    // Two-flop synchroniser plus registered rising-edge detect.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync3    <= 1'b0;
            load_acc <= 1'b0;
        end else begin
            sync1    <= load_in;
            sync2    <= sync1;
            sync3    <= sync2;
            load_acc <= sync2 & ~sync3;
        end
    end

    always_comb begin
        tick      = (ps_cnt == PS_LAST);
        all_at    = r_at & g_at & b_at;
        // A load in the same cycle as a tick wins; that tick's step is dropped.
        step      = tick & (state == ST_FADE) & ~load_acc;
        ps_clr    = load_acc | ((state == ST_IDLE) & cycle_en_in);
        pal_color = PALETTE[idx];
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ps_cnt <= '0;
        end else if (ps_clr || tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state    <= ST_IDLE;
            idx      <= '0;
            hold_cnt <= '0;
            tgt_r    <= '0;
            tgt_g    <= '0;
            tgt_b    <= '0;
            busy_out <= 1'b0;
            done_out <= 1'b0;
        end else begin
            done_out <= 1'b0;
            if (load_acc) begin
                tgt_r    <= r_tgt_in;
                tgt_g    <= g_tgt_in;
                tgt_b    <= b_tgt_in;
                state    <= ST_FADE;
                busy_out <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cycle_en_in) begin
                            {tgt_r, tgt_g, tgt_b} <= pal_color;
                            idx      <= idx + 1'b1;
                            state    <= ST_FADE;
                            busy_out <= 1'b1;
                        end
                    end
                    ST_FADE: begin
                        // Evaluated one cycle after the last step is visible.
                        if (all_at) begin
                            done_out <= 1'b1;
                            busy_out <= 1'b0;
                            hold_cnt <= '0;
                            state    <= cycle_en_in ? ST_HOLD : ST_IDLE;
                        end
                    end
                    ST_HOLD: begin
                        if (!cycle_en_in) begin
                            state <= ST_IDLE;
                        end else if (tick) begin
                            if (hold_cnt == HOLD_LAST) begin
                                {tgt_r, tgt_g, tgt_b} <= pal_color;
                                idx      <= idx + 1'b1;
                                state    <= ST_FADE;
                                busy_out <= 1'b1;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        busy_out <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Channel preset is not used by the fader; values only ever step.
    rgb_step_channel u_ch_r (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .load_val  ('0),
        .load      (1'b0),
        .step      (step),
        .target    (tgt_r),
        .value     (r_out),
        .at_target (r_at)
    );

    rgb_step_channel u_ch_g (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .load_val  ('0),
        .load      (1'b0),
        .step      (step),
        .target    (tgt_g),
        .value     (g_out),
        .at_target (g_at)
    );

    rgb_step_channel u_ch_b (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .load_val  ('0),
        .load      (1'b0),
        .step      (step),
        .target    (tgt_b),
        .value     (b_out),
        .at_target (b_at)
    );

endmodule
